// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for blocks that sit around the 4x4 booth multiplier.
//   arb_state_t    : sequencer states of the booth arbiter
//   BOOTH_WIDTH    : operand width of the booth multiplier
//   BOOTH_LATENCY  : cycles from the end of start to a valid product
//   cnt_width()    : width of a down-counter that must hold a latency value
// ---------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int BOOTH_WIDTH   = 4;
  localparam int BOOTH_LATENCY = 10;

  // A counter loaded with 'latency' and counted down to 1 must hold the
  // value 'latency' itself, hence the +1.
  function automatic int cnt_width(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/booth_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. The search starts at last+1 and
// wraps modulo N, so the requester granted most recently has lowest priority.
// Ports:
//   req     in  N   request vector
//   last    in  IW  index of the previously served requester
//   win     out N   one-hot winner (all zero when req is zero)
//   win_idx out IW  binary index of the winner (zero when req is zero)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx
);

  int   idx;
  logic found;

  // Walk the N positions after 'last' in order; the first active request
  // encountered wins and masks every later candidate.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        win[idx]   = 1'b1;
        win_idx    = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/booth_arbiter.sv
// ---------------------------------------------------------------------------
// booth_arbiter
// Shares one booth multiplier among N_REQ requesters. One request is accepted
// at a time in round-robin order, its operands are latched and presented to
// the multiplier, a start pulse is issued, the fixed multiplier latency is
// waited out and the product is returned to the winner.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   req             level request per requester
//   x_in, y_in      operand slices, requester i at [i*WIDTH +: WIDTH]
//   gnt             one-cycle one-hot pulse on acceptance
//   rsp_valid       one-cycle one-hot pulse with the product
//   rsp_data        product, held after rsp_valid drops
//   busy            high whenever the sequencer is not IDLE
//   mul_x, mul_y    latched operands to the multiplier
//   mul_start       one-cycle start pulse to the multiplier
//   mul_s           product from the multiplier
// ---------------------------------------------------------------------------
module booth_arbiter
  import booth_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = BOOTH_WIDTH,
  parameter int MUL_LATENCY = BOOTH_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] x_in,
  input  logic [N_REQ*WIDTH-1:0] y_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]     rsp_data,
  output logic                   busy,
  output logic [WIDTH-1:0]       mul_x,
  output logic [WIDTH-1:0]       mul_y,
  output logic                   mul_start,
  input  logic [2*WIDTH-1:0]     mul_s
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_width(MUL_LATENCY);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;
  logic               mul_start_q, mul_start_d;

  logic [N_REQ-1:0]   win;
  logic [IW-1:0]      win_idx;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req     (req),
    .last    (last_q),
    .win     (win),
    .win_idx (win_idx)
  );

  // Next-state logic. Pulsed outputs default low every cycle; everything
  // else holds unless the current state updates it. busy is derived from
  // the next state so that it is registered and tracks the state register.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    mul_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = win_idx;
          x_d     = x_in[win_idx*WIDTH +: WIDTH];
          y_d     = y_in[win_idx*WIDTH +: WIDTH];
          gnt_d   = win;
          state_d = START;
        end
      end
      START: begin
        mul_start_d = 1'b1;
        cnt_d       = CW'(MUL_LATENCY);
        state_d     = WAIT;
      end
      WAIT: begin
        // Leaving on a count of 1 makes WAIT last exactly MUL_LATENCY cycles.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rsp_data_d  = mul_s;
        rsp_valid_d = N_REQ'(1) << owner_q;
        last_d      = owner_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers. last resets to N_REQ-1 so requester 0 is
  // first in the round-robin order out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= IW'(N_REQ - 1);
      owner_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      mul_start_q <= mul_start_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign mul_x     = x_q;
  assign mul_y     = y_q;
  assign mul_start = mul_start_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// ---------------------------------------------------------------------------
// tb_booth_arbiter
// Bench for booth_arbiter with a behavioural booth multiplier attached to the
// mul_* ports. Expected products come from a radix-2 Booth golden model and
// are queued when a request is driven; a monitor pops and compares them as
// responses appear.
// ---------------------------------------------------------------------------
module tb_booth_arbiter;
  import booth_pkg::*;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;
  localparam int LAT   = 10;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] x_in;
  logic [N_REQ*WIDTH-1:0] y_in;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]     rsp_data;
  logic                   busy;
  logic [WIDTH-1:0]       mul_x;
  logic [WIDTH-1:0]       mul_y;
  logic                   mul_start;
  logic [2*WIDTH-1:0]     mul_s = '0;

  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] prod;
  } exp_t;

  exp_t sb_q[$];
  int   passed    = 0;
  int   total     = 0;
  int   cyc       = 0;
  int   rsp_count = 0;
  int   rsp_cyc   = 0;

  booth_arbiter #(
    .N_REQ       (N_REQ),
    .WIDTH       (WIDTH),
    .MUL_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .x_in      (x_in),
    .y_in      (y_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_start (mul_start),
    .mul_s     (mul_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Radix-2 Booth recoding of a signed 4x4 multiply.
  function automatic logic [7:0] booth_golden(input logic [3:0] m, input logic [3:0] q);
    logic [3:0] a;
    logic [3:0] qq;
    logic       q1;
    a  = '0;
    qq = q;
    q1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      case ({qq[0], q1})
        2'b10:   a = a - m;
        2'b01:   a = a + m;
        default: ;
      endcase
      {a, qq, q1} = {a[3], a, qq};
    end
    return {a, qq};
  endfunction

  function automatic logic [7:0] ref_mul(input logic signed [7:0] a, input logic signed [7:0] b);
    return 8'(a * b);
  endfunction

  function automatic logic [N_REQ-1:0] oh(input int i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Behavioural multiplier: garbage while computing, product valid LAT
  // cycles after the end of the start pulse.
  int         pend = 0;
  logic [7:0] mul_res = '0;
  always @(posedge clk) begin
    if (mul_start) begin
      pend    <= LAT - 1;
      mul_s   <= 8'h5A;
      mul_res <= ref_mul($signed(mul_x), $signed(mul_y));
    end else if (pend == 1) begin
      mul_s <= mul_res;
      pend  <= 0;
    end else if (pend > 1) begin
      pend <= pend - 1;
    end
  end

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset && rsp_valid != '0) begin
      rsp_count++;
      rsp_cyc = cyc;
      total++;
      if (sb_q.size() == 0) begin
        $display("[TB] FAIL unexpected_rsp rsp_valid=%b rsp_data=%h required none", rsp_valid, rsp_data);
      end else begin
        e = sb_q.pop_front();
        if (rsp_valid !== oh(int'(e.idx)) || rsp_data !== e.prod)
          $display("[TB] FAIL rsp got valid=%b data=%h required valid=%b data=%h",
                   rsp_valid, rsp_data, oh(int'(e.idx)), e.prod);
        else
          passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input int i, input logic [3:0] x, input logic [3:0] y);
    x_in[i*WIDTH +: WIDTH] = x;
    y_in[i*WIDTH +: WIDTH] = y;
  endtask

  task automatic push_exp(input int i, input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    e.idx  = 8'(i);
    e.prod = booth_golden(x, y);
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({gnt, rsp_valid, rsp_data, busy, mul_x, mul_y, mul_start} !== '0)
      $display("[TB] FAIL reset_outputs got gnt=%b rv=%b data=%h busy=%b x=%h y=%h st=%b required all 0",
               gnt, rsp_valid, rsp_data, busy, mul_x, mul_y, mul_start);
    else passed++;
    reset = 1'b0;
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || gnt !== '0)
      $display("[TB] FAIL idle_after_reset got busy=%b gnt=%b required 0/0", busy, gnt);
    else passed++;
  endtask

  task automatic test_single();
    int t0, k, rc0;
    rc0 = rsp_count;
    set_ops(0, 4'd3, 4'd5);
    push_exp(0, 4'd3, 4'd5);
    req = 4'b0001;
    tick();
    t0 = cyc;
    total++;
    if (gnt !== 4'b0001 || busy !== 1'b1)
      $display("[TB] FAIL single_gnt got gnt=%b busy=%b required 0001/1", gnt, busy);
    else passed++;
    req = '0;
    tick();
    total++;
    if (mul_start !== 1'b1 || mul_x !== 4'd3 || mul_y !== 4'd5 || gnt !== '0)
      $display("[TB] FAIL single_start got st=%b x=%h y=%h gnt=%b required 1/3/5/0", mul_start, mul_x, mul_y, gnt);
    else passed++;
    tick();
    total++;
    if (mul_start !== 1'b0 || mul_x !== 4'd3)
      $display("[TB] FAIL single_start_pulse got st=%b x=%h required 0/3", mul_start, mul_x);
    else passed++;
    k = 0;
    while (rsp_count < rc0 + 1 && k < 40) begin tick(); k++; end
    total++;
    if (rsp_count != rc0 + 1 || rsp_cyc - t0 != LAT + 2)
      $display("[TB] FAIL single_latency got rsps=%0d latency=%0d required 1/%0d", rsp_count - rc0, rsp_cyc - t0, LAT + 2);
    else passed++;
    tick();
    total++;
    if (rsp_valid !== '0 || rsp_data !== 8'd15 || busy !== 1'b0)
      $display("[TB] FAIL single_hold got rv=%b data=%h busy=%b required 0000/0f/0", rsp_valid, rsp_data, busy);
    else passed++;
  endtask

  task automatic test_all_four();
    int g_exp[5] = '{0, 1, 2, 3, 0};
    logic [3:0] xs[4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    logic [3:0] ys[4] = '{4'd2, 4'd3, 4'hD, 4'd5};
    int gi, k, rc0, prev;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    rc0 = rsp_count;
    for (int i = 0; i < 4; i++) set_ops(i, xs[i], ys[i]);
    for (int i = 0; i < 5; i++) push_exp(g_exp[i], xs[g_exp[i]], ys[g_exp[i]]);
    req  = 4'b1111;
    gi   = 0;
    k    = 0;
    prev = 0;
    while (rsp_count < rc0 + 5 && k < 120) begin
      tick();
      k++;
      if (gnt != '0) begin
        total++;
        if (gi >= 5 || gnt !== oh(g_exp[gi]))
          $display("[TB] FAIL rr_order grant#%0d got gnt=%b required %b", gi, gnt, (gi < 5) ? oh(g_exp[gi]) : '0);
        else passed++;
        gi++;
        if (gi == 5) req = '0;
      end
      if (rsp_cyc == cyc && rsp_count > rc0 + 1) begin
        total++;
        if (rsp_cyc - prev != LAT + 3)
          $display("[TB] FAIL rr_spacing got %0d cycles required %0d", rsp_cyc - prev, LAT + 3);
        else passed++;
      end
      if (rsp_cyc == cyc) prev = rsp_cyc;
    end
    total++;
    if (rsp_count != rc0 + 5 || gi != 5)
      $display("[TB] FAIL rr_count got rsps=%0d grants=%0d required 5/5", rsp_count - rc0, gi);
    else passed++;
    req = '0;
  endtask

  task automatic test_signed();
    int k, rc0;
    logic [7:0] s_at_done;
    rc0 = rsp_count;
    set_ops(2, 4'b1001, 4'b0111);
    push_exp(2, 4'b1001, 4'b0111);
    req = 4'b0100;
    tick();
    total++;
    if (gnt !== 4'b0100)
      $display("[TB] FAIL signed_gnt got gnt=%b required 0100", gnt);
    else passed++;
    req = '0;
    k = 0;
    s_at_done = mul_s;
    while (rsp_count < rc0 + 1 && k < 40) begin
      s_at_done = mul_s;
      tick();
      k++;
    end
    total++;
    if (rsp_count != rc0 + 1 || rsp_data !== s_at_done || rsp_data !== 8'hCF)
      $display("[TB] FAIL signed_data got data=%h mul_s_at_done=%h required cf", rsp_data, s_at_done);
    else passed++;
  endtask

  task automatic test_withdraw();
    int k, rc0, g2, r2;
    rc0 = rsp_count;
    g2  = 0;
    r2  = 0;
    set_ops(0, 4'd6, 4'd2);
    set_ops(2, 4'd7, 4'd7);
    push_exp(0, 4'd6, 4'd2);
    req = 4'b0001;
    tick();
    total++;
    if (gnt !== 4'b0001)
      $display("[TB] FAIL withdraw_gnt0 got gnt=%b required 0001", gnt);
    else passed++;
    req = '0;
    k = 0;
    while (k < LAT + 10) begin
      if (k == 3) req[2] = 1'b1;
      if (k == 6) req[2] = 1'b0;
      tick();
      k++;
      if (gnt[2]) g2++;
      if (rsp_valid[2]) r2++;
    end
    total++;
    if (g2 != 0 || r2 != 0 || rsp_count != rc0 + 1)
      $display("[TB] FAIL withdraw got gnt2=%0d rsp2=%0d rsps=%0d required 0/0/1", g2, r2, rsp_count - rc0);
    else passed++;
  endtask

  task automatic test_reset_wait();
    int k, rc0;
    set_ops(1, 4'd5, 4'd5);
    req = 4'b0010;
    tick();
    total++;
    if (gnt !== 4'b0010)
      $display("[TB] FAIL abort_gnt1 got gnt=%b required 0010", gnt);
    else passed++;
    req = '0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    total++;
    if ({gnt, rsp_valid, rsp_data, busy, mul_x, mul_y, mul_start} !== '0)
      $display("[TB] FAIL abort_outputs got gnt=%b rv=%b data=%h busy=%b x=%h y=%h st=%b required all 0",
               gnt, rsp_valid, rsp_data, busy, mul_x, mul_y, mul_start);
    else passed++;
    tick();
    reset = 1'b0;
    rc0 = rsp_count;
    for (int i = 0; i < LAT + 5; i++) tick();
    total++;
    if (rsp_count != rc0 || busy !== 1'b0)
      $display("[TB] FAIL abort_stale got rsps=%0d busy=%b required 0/0", rsp_count - rc0, busy);
    else passed++;
    set_ops(0, 4'd2, 4'hE);
    set_ops(2, 4'd3, 4'd3);
    push_exp(0, 4'd2, 4'hE);
    req = 4'b0101;
    tick();
    total++;
    if (gnt !== 4'b0001)
      $display("[TB] FAIL abort_first_prio got gnt=%b required 0001", gnt);
    else passed++;
    req = '0;
    k = 0;
    while (rsp_count < rc0 + 1 && k < 40) begin tick(); k++; end
    total++;
    if (rsp_count != rc0 + 1)
      $display("[TB] FAIL abort_rsp_timeout got rsps=%0d required 1", rsp_count - rc0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int g_exp[2] = '{3, 1};
    int t0, gi, k, rc0;
    rc0 = rsp_count;
    set_ops(1, 4'd7, 4'd3);
    push_exp(1, 4'd7, 4'd3);
    req = 4'b0010;
    tick();
    t0 = cyc;
    total++;
    if (gnt !== 4'b0010)
      $display("[TB] FAIL b2b_gnt1 got gnt=%b required 0010", gnt);
    else passed++;
    set_ops(3, 4'hB, 4'd2);
    push_exp(3, 4'hB, 4'd2);
    req = 4'b1000;
    k = 0;
    while (cyc < t0 + LAT + 1 && k < 40) begin tick(); k++; end
    set_ops(1, 4'd4, 4'hC);
    push_exp(1, 4'd4, 4'hC);
    req = 4'b1010;
    gi = 0;
    k = 0;
    while (rsp_count < rc0 + 3 && k < 80) begin
      tick();
      k++;
      if (gnt != '0) begin
        total++;
        if (gi >= 2 || gnt !== oh(g_exp[gi]))
          $display("[TB] FAIL b2b_order grant#%0d got gnt=%b required %b", gi, gnt, (gi < 2) ? oh(g_exp[gi]) : '0);
        else passed++;
        if (gi == 0) req[3] = 1'b0;
        else req = '0;
        gi++;
      end
    end
    total++;
    if (rsp_count != rc0 + 3 || gi != 2)
      $display("[TB] FAIL b2b_count got rsps=%0d grants=%0d required 3/2", rsp_count - rc0, gi);
    else passed++;
    req = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    x_in  = '0;
    y_in  = '0;
    test_reset();
    test_single();
    test_all_four();
    test_signed();
    test_withdraw();
    test_reset_wait();
    test_back_to_back();
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (sb_q.size() != 0)
      $display("[TB] FAIL scoreboard_drain got %0d pending required 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
